// File: rtl/dispatcher.sv
// Dispatcher: accepts one element per cycle and parks it in a free one-entry
// output lane. Lane choice is fixed-priority (lowest or highest index first)
// or round-robin. Each lane is drained independently by its consumer.

`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif

module dispatcher #(
    parameter int DATA = 8,
    parameter int OUT  = 4,
    parameter bit MSB  = `Disable,
    parameter bit RR   = `Disable
) (
    input  logic                           clk,
    input  logic                           reset_,
    input  logic                           flush,
    input  logic                           in_valid,
    input  logic [DATA-1:0]                in_data,
    output logic                           in_ready,
    output logic [OUT-1:0]                 out_valid,
    output logic [OUT-1:0][DATA-1:0]       out_data,
    input  logic [OUT-1:0]                 out_ready,
    output logic [OUT-1:0]                 pos,
    output logic [$clog2(OUT+1)-1:0]       occ
);

    localparam int PW = $clog2(OUT);
    localparam int CW = $clog2(OUT+1);

    logic [OUT-1:0]            valid_q, valid_d;
    logic [OUT-1:0][DATA-1:0]  data_q,  data_d;
    logic [OUT-1:0]            pos_q,   pos_d;
    logic [PW-1:0]             ptr_q,   ptr_d;

    logic [OUT-1:0]            free;
    logic [OUT-1:0]            drain;
    logic [OUT-1:0]            tgt_oh;
    logic [PW-1:0]             tgt_idx;
    logic                      found;
    logic                      accept;
    logic [CW-1:0]             occ_c;

    // Lane visited at search step j: rotated from ptr in round-robin mode,
    // otherwise a straight walk from the top or bottom index.
    function automatic int lane_at(input int j, input logic [PW-1:0] p);
        int s;
        if (RR) begin
            s = int'(p) + j;
            return (s >= OUT) ? s - OUT : s;
        end else if (MSB) begin
            return OUT - 1 - j;
        end else begin
            return j;
        end
    endfunction

    // Target search: first free lane in the mode-specific search order.
    // NOTE: every variable written here gets a default before any condition,
    // otherwise synthesis infers a latch for paths that leave it unassigned.
    always_comb begin
        free    = ~valid_q;
        tgt_oh  = '0;
        tgt_idx = '0;
        found   = 1'b0;
        for (int j = 0; j < OUT; j++) begin
            if (!found && free[lane_at(j, ptr_q)]) begin
                found                  = 1'b1;
                tgt_idx                = PW'(lane_at(j, ptr_q));
                tgt_oh[lane_at(j, ptr_q)] = 1'b1;
            end
        end
    end

    // Handshake: ready depends only on registered lane state and flush.
    always_comb begin
        in_ready = (|free) & ~flush;
        accept   = in_valid & in_ready;
        drain    = valid_q & out_ready;
    end

    // Next-state: drains, the accept into the target lane, pointer and pos.
    // Draining lanes are never free, so drain and accept never collide.
    always_comb begin
        valid_d = valid_q & ~drain;
        data_d  = data_q;
        pos_d   = '0;
        ptr_d   = ptr_q;
        if (flush) begin
            valid_d = '0;
            ptr_d   = '0;
        end else if (accept) begin
            valid_d[tgt_idx] = 1'b1;
            data_d[tgt_idx]  = in_data;
            pos_d            = tgt_oh;
            if (RR) begin
                ptr_d = (tgt_idx == PW'(OUT - 1)) ? '0 : tgt_idx + PW'(1);
            end
        end
    end

    // Lane occupancy count.
    always_comb begin
        occ_c = '0;
        for (int i = 0; i < OUT; i++) begin
            occ_c = occ_c + CW'(valid_q[i]);
        end
    end

    // State registers; the lane data is cleared too so outputs read 0 in reset.
    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            valid_q <= '0;
            data_q  <= '0;
            pos_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pos_q   <= pos_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign pos       = pos_q;
    assign occ       = occ_c;

endmodule

// File: doc/dispatcher.md
DISPATCHER -- requirements
Module: dispatcher

Interface
REQ-001 Parameter DATA, default 8: width of one data element, at least 1.
REQ-002 Parameter OUT, default 4: number of output lanes, at least 2.
REQ-003 Parameter MSB, default `Disable: in fixed-priority mode, search from the highest lane index instead of the lowest.
REQ-004 Parameter RR, default `Disable: when `Enable, lane selection is round-robin; MSB is ignored.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset_  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous, active-high clear of all lane contents.
REQ-008 in_valid  input  1  input element offered.
REQ-009 in_data  input  DATA  input element.
REQ-010 in_ready  output  1  dispatcher can accept the element this cycle.
REQ-011 out_valid  output  OUT  per-lane element held.
REQ-012 out_data  output  [OUT-1:0][DATA-1:0]  per-lane held element.
REQ-013 out_ready  input  OUT  per-lane consumer accepts.
REQ-014 pos  output  OUT  one-hot lane written by the previous cycle's accept; all-zero otherwise.
REQ-015 occ  output  $clog2(OUT+1)  number of lanes with out_valid set.

Function
REQ-016 Each lane holds a one-entry register: a valid bit plus DATA bits.
REQ-017 A lane is free when its registered valid bit is 0. A lane draining in the current cycle is not free.
REQ-018 in_ready = OR of free lanes AND NOT flush. It is combinational from registered state and flush only, and never depends on in_valid.
REQ-019 Accept = in_valid AND in_ready. On accept, exactly one free lane (the target) loads in_data and sets valid at the next edge. Latency is 1 cycle.
REQ-020 Fixed priority (RR=0, MSB=0): the target is the lowest-index free lane.
REQ-021 Fixed priority (RR=0, MSB=1): the target is the highest-index free lane.
REQ-022 Round-robin (RR=1): the pointer ptr is $clog2(OUT) bits. Search runs ptr, ptr+1, ... modulo OUT; the target is the first free lane found. After an accept to lane k, ptr becomes (k+1) mod OUT. ptr is unchanged when there is no accept.
REQ-023 Wrap-around: for non-power-of-2 OUT, ptr never exceeds OUT-1. From lane OUT-1, ptr wraps to 0.
REQ-024 Drain: when out_valid[i] AND out_ready[i], lane i clears valid at the next edge. out_data[i] keeps its last value.
REQ-025 Drains on several lanes in the same cycle are all honoured. An accept and drains in the same cycle always target different lanes.
REQ-026 out_valid[i], once set, stays set and out_data[i] stays stable until drained or flushed.
REQ-027 pos: registered one-hot of the target when there was an accept in the previous cycle; 0 otherwise.
REQ-028 occ: popcount of the registered lane valid bits, consistent with out_valid every cycle.
REQ-029 flush: at the next edge, all lane valid bits and pos are set to 0, and ptr is set to 0. The in_valid of the flush cycle is not accepted because in_ready=0. Drains in the flush cycle are discarded.
REQ-030 Full: with all lanes valid, in_ready=0. in_data is ignored and no state changes except drains.
REQ-031 Empty: with occ=0, in_ready=1 (when flush=0) and out_valid=0.

Reset
REQ-032 While reset_=0: out_valid=0, pos=0, occ=0, ptr=0, out_data=0. in_ready=1 because all lanes are free.
REQ-033 Assertion takes effect immediately, without waiting for a clock edge.
REQ-034 Reset mid-operation discards all held elements. The first accept after release targets lane 0 (RR, or MSB=0) or lane OUT-1 (MSB=1).

Verification (OUT=4, DATA=8)
REQ-035 RR=0, MSB=0; out_ready=0; accept 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required: lanes 0..3 hold those values; pos = 0001, 0010, 0100, 1000; occ reaches 4; in_ready=0 on the fifth cycle.
REQ-036 RR=0, MSB=1; from empty, accept 0xA5. Required: out_valid=1000, out_data[3]=0xA5, pos=1000.
REQ-037 RR=1; lanes 0..3 full; drain lane 1 only (out_ready=0010); then accept 0x5A. Required: 0x5A lands in lane 1 and ptr=2. A following drain of lane 0 plus accept of 0x6B places 0x6B in lane 0 (wrap).
REQ-038 Simultaneous events: lane 2 is the only full lane; out_ready=0100 and in_valid=1 with 0x77 in the same cycle. Required (RR=0, MSB=0): 0x77 goes to lane 0, lane 2 clears, occ stays 1.
REQ-039 flush with 3 lanes full and in_valid=1. Required: in_ready=0 that cycle; next cycle out_valid=0000, occ=0, pos=0000.
REQ-040 Assert reset_=0 asynchronously mid-stream with 2 lanes full. Required: out_valid=0 and occ=0 before the next clock edge; after release, the first accept sets pos=0001 (RR=1).
